// File: rtl/scr_base_l3_bk_tp_d0.sv
// L3 bank tag pipe D0: arbitrates request sources, filters in-flight set hazards,
// issues the tag read for the winner and registers it into the D0->D1 pipe register.
module scr_base_l3_bk_tp_d0 #(
  parameter int N_SRC     = 3,
  parameter int ADDR_W    = 40,
  parameter int ID_W      = 8,
  parameter int OP_W      = 4,
  parameter int SET_W     = 10,
  parameter int OFFS_W    = 6,
  parameter int STARVE_TH = 4
) (
  input  logic                     rst_n,
  input  logic                     clk,
  input  logic [N_SRC-1:0]         src_req_vld,
  output logic [N_SRC-1:0]         src_req_rdy,
  input  logic [N_SRC*ADDR_W-1:0]  src_req_addr,
  input  logic [N_SRC*ID_W-1:0]    src_req_id,
  input  logic [N_SRC*OP_W-1:0]    src_req_op,
  input  logic                     set_blk_vld,
  input  logic [SET_W-1:0]         set_blk_idx,
  output logic                     tag_rd_en,
  output logic [SET_W-1:0]         tag_rd_set,
  output logic                     d1_vld,
  input  logic                     d1_rdy,
  output logic [ADDR_W-1:0]        d1_addr,
  output logic [ID_W-1:0]          d1_id,
  output logic [OP_W-1:0]          d1_op,
  output logic [N_SRC-1:0]         d1_src
);

  localparam int CNT_W = $clog2(STARVE_TH + 1);
  localparam int PTR_W = $clog2(N_SRC);

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] grant;
  logic             adv;
  logic             found;
  logic [SET_W-1:0] src_set [N_SRC];

  logic [PTR_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q [1:N_SRC-1];
  logic [CNT_W-1:0] cnt_d [1:N_SRC-1];

  logic              d1_vld_q, d1_vld_d;
  logic [ADDR_W-1:0] d1_addr_q, d1_addr_d;
  logic [ID_W-1:0]   d1_id_q, d1_id_d;
  logic [OP_W-1:0]   d1_op_q, d1_op_d;
  logic [N_SRC-1:0]  d1_src_q, d1_src_d;

  assign adv = !d1_vld_q || d1_rdy;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_set[i] = src_req_addr[i*ADDR_W + OFFS_W +: SET_W];
      elig[i]    = src_req_vld[i] && !(set_blk_vld && (src_set[i] == set_blk_idx));
    end
  end

  // Priority: starved external source, then replay source 0, then round-robin from rr_q.
  always_comb begin
    int j;
    grant = '0;
    found = 1'b0;
    j     = 0;
    if (rst_n && adv) begin
      for (int i = 1; i < N_SRC; i++) begin
        if (!found && elig[i] && (cnt_q[i] == CNT_W'(STARVE_TH))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      if (!found && elig[0]) begin
        grant[0] = 1'b1;
        found    = 1'b1;
      end
      for (int k = 0; k < N_SRC - 1; k++) begin
        j = int'(rr_q) + k;
        if (j > N_SRC - 1) j = j - (N_SRC - 1);
        if (!found && elig[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tag_rd_set = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) tag_rd_set = src_set[i];
    end
  end

  assign src_req_rdy = grant;
  assign tag_rd_en   = |grant;

  always_comb begin
    rr_d = rr_q;
    for (int i = 1; i < N_SRC; i++) begin
      if (grant[i]) rr_d = (i == N_SRC - 1) ? PTR_W'(1) : PTR_W'(i + 1);
      if (!src_req_vld[i] || grant[i]) begin
        cnt_d[i] = '0;
      end else if (adv && elig[i] && (cnt_q[i] != CNT_W'(STARVE_TH))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_comb begin
    d1_vld_d  = d1_vld_q;
    d1_addr_d = d1_addr_q;
    d1_id_d   = d1_id_q;
    d1_op_d   = d1_op_q;
    d1_src_d  = d1_src_q;
    if (|grant) begin
      d1_vld_d = 1'b1;
      d1_src_d = grant;
      for (int i = 0; i < N_SRC; i++) begin
        if (grant[i]) begin
          d1_addr_d = src_req_addr[i*ADDR_W +: ADDR_W];
          d1_id_d   = src_req_id[i*ID_W +: ID_W];
          d1_op_d   = src_req_op[i*OP_W +: OP_W];
        end
      end
    end else if (d1_rdy) begin
      d1_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= PTR_W'(1);
      d1_vld_q  <= 1'b0;
      d1_addr_q <= '0;
      d1_id_q   <= '0;
      d1_op_q   <= '0;
      d1_src_q  <= '0;
      for (int i = 1; i < N_SRC; i++) cnt_q[i] <= '0;
    end else begin
      rr_q      <= rr_d;
      d1_vld_q  <= d1_vld_d;
      d1_addr_q <= d1_addr_d;
      d1_id_q   <= d1_id_d;
      d1_op_q   <= d1_op_d;
      d1_src_q  <= d1_src_d;
      for (int i = 1; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign d1_vld  = d1_vld_q;
  assign d1_addr = d1_addr_q;
  assign d1_id   = d1_id_q;
  assign d1_op   = d1_op_q;
  assign d1_src  = d1_src_q;

endmodule

// File: tb/tb_scr_base_l3_bk_tp_d0.sv
// Scoreboard bench for the L3 tag pipe D0 stage: a rule-level arbitration model predicts
// each cycle's grant and pushes the expected D1 contents; a monitor checks D1 handshakes.
module tb_scr_base_l3_bk_tp_d0;
  localparam int N = 3, AW = 40, IW = 8, OW = 4, SW = 10, OFW = 6, TH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    src_req_vld, src_req_rdy;
  logic [N*AW-1:0] src_req_addr;
  logic [N*IW-1:0] src_req_id;
  logic [N*OW-1:0] src_req_op;
  logic            set_blk_vld;
  logic [SW-1:0]   set_blk_idx;
  logic            tag_rd_en;
  logic [SW-1:0]   tag_rd_set;
  logic            d1_vld, d1_rdy;
  logic [AW-1:0]   d1_addr;
  logic [IW-1:0]   d1_id;
  logic [OW-1:0]   d1_op;
  logic [N-1:0]    d1_src;

  scr_base_l3_bk_tp_d0 #(.N_SRC(N), .ADDR_W(AW), .ID_W(IW), .OP_W(OW), .SET_W(SW),
                         .OFFS_W(OFW), .STARVE_TH(TH)) dut (
    .rst_n(rst_n), .clk(clk),
    .src_req_vld(src_req_vld), .src_req_rdy(src_req_rdy), .src_req_addr(src_req_addr),
    .src_req_id(src_req_id), .src_req_op(src_req_op),
    .set_blk_vld(set_blk_vld), .set_blk_idx(set_blk_idx),
    .tag_rd_en(tag_rd_en), .tag_rd_set(tag_rd_set),
    .d1_vld(d1_vld), .d1_rdy(d1_rdy), .d1_addr(d1_addr), .d1_id(d1_id),
    .d1_op(d1_op), .d1_src(d1_src)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [OW-1:0] op;
    logic [N-1:0]  src;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Source-side pending requests (held until granted) and next-cycle controls
  logic          p_vld [N];
  logic [AW-1:0] p_addr [N];
  logic [IW-1:0] p_id [N];
  logic [OW-1:0] p_op [N];
  logic          nxt_rdy, nxt_blk_vld;
  logic [SW-1:0] nxt_blk_idx;

  // Reference model state
  int rr;
  int cnt [N];
  bit m_vld;
  int last_win;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int set_of(input logic [AW-1:0] a);
    return int'((a >> OFW) & ((1 << SW) - 1));
  endfunction

  task automatic model_reset();
    rr = 1;
    m_vld = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    sb.delete();
  endtask

  task automatic new_req(input int i, input int setv);
    logic [AW-1:0] a;
    a = {$urandom, $urandom};
    a[OFW +: SW] = SW'(setv);
    p_vld[i]  = 1'b1;
    p_addr[i] = a;
    p_id[i]   = IW'($urandom);
    p_op[i]   = OW'($urandom);
  endtask

  function automatic int pick_set();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 'h049;
    if (r == 1) return 'h050;
    return $urandom_range(0, (1 << SW) - 1);
  endfunction

  task automatic drive_pins();
    for (int i = 0; i < N; i++) begin
      src_req_vld[i]            = p_vld[i];
      src_req_addr[i*AW +: AW]  = p_addr[i];
      src_req_id[i*IW +: IW]    = p_id[i];
      src_req_op[i*OW +: OW]    = p_op[i];
    end
    d1_rdy      = nxt_rdy;
    set_blk_vld = nxt_blk_vld;
    set_blk_idx = nxt_blk_idx;
  endtask

  // Predict this cycle's winner from the arbitration rules and check the combinational outputs.
  task automatic step();
    bit adv;
    bit el [N];
    int win;
    int j;
    exp_t e;
    adv = !m_vld || nxt_rdy;
    for (int i = 0; i < N; i++)
      el[i] = p_vld[i] && !(nxt_blk_vld && set_of(p_addr[i]) == int'(nxt_blk_idx));
    win = -1;
    if (adv) begin
      for (int i = 1; i < N && win < 0; i++)
        if (el[i] && cnt[i] == TH) win = i;
      if (win < 0 && el[0]) win = 0;
      for (int k = 0; k < N - 1 && win < 0; k++) begin
        j = 1 + ((rr - 1 + k) % (N - 1));
        if (el[j]) win = j;
      end
    end
    chk("grant", 64'(src_req_rdy), (win >= 0) ? 64'(1 << win) : 64'd0);
    chk("tag_rd_en", 64'(tag_rd_en), 64'(win >= 0));
    if (win >= 0) begin
      chk("tag_rd_set", 64'(tag_rd_set), 64'(set_of(p_addr[win])));
      e.addr = p_addr[win];
      e.id   = p_id[win];
      e.op   = p_op[win];
      e.src  = N'(1 << win);
      sb.push_back(e);
    end
    for (int i = 1; i < N; i++) begin
      if (!p_vld[i] || i == win) cnt[i] = 0;
      else if (adv && el[i] && cnt[i] < TH) cnt[i]++;
    end
    if (win >= 1) rr = (win == N - 1) ? 1 : win + 1;
    if (win >= 0) m_vld = 1;
    else if (nxt_rdy) m_vld = 0;
    if (win >= 0) p_vld[win] = 1'b0;
    last_win = win;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #2;
    drive_pins();
    #2;
    step();
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) p_vld[i] = 1'b0;
    nxt_rdy = 1'b1;
    nxt_blk_vld = 1'b0;
    nxt_blk_idx = '0;
  endtask

  // Monitor: every D1 handshake must match the oldest predicted grant
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && d1_vld && d1_rdy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("d1_addr", 64'(d1_addr), 64'(e.addr));
          chk("d1_id", 64'(d1_id), 64'(e.id));
          chk("d1_op", 64'(d1_op), 64'(e.op));
          chk("d1_src", 64'(d1_src), 64'(e.src));
        end
      end
    end
  end

  initial begin
    int exp_w [6];
    int seq [5];

    // Reset state, with every source valid so combinational gating is exercised
    clear_srcs();
    for (int i = 0; i < N; i++) new_req(i, pick_set());
    drive_pins();
    model_reset();
    #3;
    chk("rst_d1_vld", 64'(d1_vld), 64'd0);
    chk("rst_d1_addr", 64'(d1_addr), 64'd0);
    chk("rst_d1_id_op_src", 64'({d1_id, d1_op, d1_src}), 64'd0);
    chk("rst_rdy", 64'(src_req_rdy), 64'd0);
    chk("rst_tag_rd_en", 64'(tag_rd_en), 64'd0);
    src_req_vld = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin: src1/src2 always valid
    clear_srcs();
    seq = '{1, 2, 1, 2, 1};
    for (int k = 0; k < 5; k++) begin
      for (int i = 1; i < N; i++) if (!p_vld[i]) new_req(i, pick_set());
      run_cycle();
      chk("rr_order", 64'(last_win), 64'(seq[k]));
    end

    // Single request from the worked example
    clear_srcs();
    run_cycle();
    p_vld[1] = 1'b1; p_addr[1] = 40'h00_0000_1240; p_id[1] = 8'd5; p_op[1] = 4'h3;
    run_cycle();
    chk("single_rdy", 64'(src_req_rdy), 64'b010);
    chk("single_set", 64'(tag_rd_set), 64'h049);
    run_cycle();
    chk("single_d1_vld", 64'(d1_vld), 64'd1);
    chk("single_d1_addr", 64'(d1_addr), 64'h1240);
    chk("single_d1_id", 64'(d1_id), 64'd5);
    chk("single_d1_src", 64'(d1_src), 64'b010);

    // Set hazard: blocked src1, then blocked alone, then released
    clear_srcs();
    nxt_blk_vld = 1'b1; nxt_blk_idx = 10'h049;
    new_req(1, 'h049); new_req(2, 'h050);
    run_cycle();
    chk("hazard_win_src2", 64'(last_win), 64'd2);
    run_cycle();
    chk("hazard_blocked", 64'(last_win), 64'hffff_ffff_ffff_ffff);
    nxt_blk_vld = 1'b0;
    run_cycle();
    chk("hazard_release", 64'(last_win), 64'd1);

    // Backpressure: grant, three stalled cycles, accept on d1_rdy return
    clear_srcs();
    seq = '{1, -1, -1, -1, 1};
    for (int k = 0; k < 5; k++) begin
      nxt_rdy = (k == 0 || k == 4);
      if (!p_vld[1]) new_req(1, pick_set());
      run_cycle();
      chk("bp_win", 64'(last_win), 64'(seq[k]));
    end

    // Randomized traffic
    clear_srcs();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!p_vld[i] && $urandom_range(0, 99) < 55) new_req(i, pick_set());
      nxt_rdy = ($urandom_range(0, 99) < 70);
      nxt_blk_vld = ($urandom_range(0, 99) < 35);
      nxt_blk_idx = SW'(pick_set());
      run_cycle();
    end

    // Async reset mid-cycle while the register is loaded
    clear_srcs();
    new_req(2, pick_set());
    run_cycle();
    @(posedge clk);
    #3;
    chk("prereset_d1_vld", 64'(d1_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_d1_vld", 64'(d1_vld), 64'd0);
    chk("midrst_rdy", 64'(src_req_rdy), 64'd0);
    src_req_vld = '0;
    model_reset();
    clear_srcs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Starvation right after reset: src1 promoted after four losses
    exp_w = '{0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      if (!p_vld[0]) new_req(0, pick_set());
      if (!p_vld[1]) new_req(1, pick_set());
      run_cycle();
      chk("starve_win", 64'(last_win), 64'(exp_w[k]));
    end

    // Drain
    clear_srcs();
    for (int k = 0; k < 4; k++) run_cycle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
